univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register, the successor to the fixed single-bit SISO register. It supports hold, shift-right, shift-left and parallel load in one clocked block, with serial ports at both ends and a full parallel output, so it can act as a SISO, SIPO, PISO or PIPO stage. A shift counter raises a one-cycle `word_done` strobe after every WIDTH shifts, which lets serial links frame words without an external counter.

## Interface
- `WIDTH`, default 8: register length in bits; legal values ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: shift counter width; derived, do not override.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `en`  in  1  clock enable; when 0, all state holds.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `sin_r`  in  1  serial input; enters at bit WIDTH-1 on a right shift.
- `sin_l`  in  1  serial input; enters at bit 0 on a left shift.
- `pin`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `sout_r`  out  1  right-end serial output, equal to `q[0]`.
- `sout_l`  out  1  left-end serial output, equal to `q[WIDTH-1]`.
- `shift_cnt`  out  CNT_W  shifts completed since the last load, reset or wrap; range 0..WIDTH-1.
- `word_done`  out  1  one-cycle strobe marking WIDTH completed shifts.

## Operation
- Priority per rising edge, highest first: reset (`rst`=0), then `en`=0, then `mode`.
- Reset:
  - `q` ← 0, `shift_cnt` ← 0, `word_done` ← 0.
  - Reset overrides `en` and `mode`, including reset mid-word; the partial word is discarded.
- `en`=0: `q` and `shift_cnt` hold; `word_done` ← 0.
- Mode 00 (hold): `q` and `shift_cnt` hold; `word_done` ← 0.
- Mode 01 (shift right): `q` ← {`sin_r`, `q[WIDTH-1:1]`}.
- Mode 10 (shift left): `q` ← {`q[WIDTH-2:0]`, `sin_l`}.
- Mode 11 (parallel load): `q` ← `pin`, `shift_cnt` ← 0, `word_done` ← 0.
- Counter on every shift (mode 01 or 10 with `en`=1):
  - If `shift_cnt` = WIDTH-1: `shift_cnt` ← 0 and `word_done` ← 1.
  - Otherwise: `shift_cnt` ← `shift_cnt`+1 and `word_done` ← 0.
- Changing direction mid-word does not reset the counter; shifts in either direction count equally.
- A load on the cycle that would have been the WIDTH-th shift takes precedence: no `word_done`, and the counter clears.
- `sout_r` and `sout_l` are combinational taps of `q`. `q`, `shift_cnt` and `word_done` are registered outputs.

## Timing
- Latency from mode/data inputs to `q` is one clock edge.
- Serial outputs reflect `q` in the same cycle as the update.
- SISO path, right shift: the bit on `sin_r` captured at edge k appears on `sout_r` after edge k+WIDTH-1, i.e. WIDTH edges counting the capture edge. The left-shift path is symmetric.
- PISO path: after a load of value P, `sout_r` shows P[0] immediately. Each following right shift exposes P[1], P[2], …, P[WIDTH-1].
- `word_done` is high for exactly one cycle, following the edge that registers the WIDTH-th shift.
  - With continuous shifting it pulses every WIDTH cycles.
  - Back-to-back words need no idle cycle.
- Deasserting `en` freezes the word position. Shifting resumes the count where it stopped.
- Reset deassertion: the first edge with `rst`=1 performs a normal operation. No warm-up cycle.

## Test plan
All scenarios use WIDTH=4.
- **Reset:** hold `rst`=0 for 2 edges with `mode`=11, `pin`=4'hF → `q`=0, `shift_cnt`=0, `word_done`=0. This confirms reset beats load.
- **SISO right:** `mode`=01, drive `sin_r` = 1,0,1,1 on successive edges → `q`=4'b1101 after the 4th edge; `sout_r` shows the first bit (1) after edge 4; `word_done`=1 for one cycle only.
- **PISO:**
  - Load `pin`=4'b1011, then `mode`=01 for 4 edges with `sin_r`=0.
  - Required `sout_r` sequence: 1 (after load), then 1, 0, 1, 0; final `q`=0.
  - `word_done` pulses after edge 4.
- **Left shift and enable:**
  - `mode`=10, `sin_l`=1 for 2 edges, then `en`=0 for 3 edges, then 2 more shifts.
  - `q` = 4'b0011, holding through the `en`=0 edges, then 4'b1111.
  - `shift_cnt` holds at 2 while `en`=0.
  - `word_done` is asserted only after the 4th shift.
- **Reset and load mid-word:**
  - After 3 shifts, apply `rst`=0 for one edge, then 4 shifts: `word_done` fires only after the 4th post-reset shift.
  - Repeat with `mode`=11 on the would-be 4th edge: no `word_done`, `shift_cnt`=0.
- **Direction mix:** right, right, left, left shifts from `q`=4'b1000 with `sin_r`=`sin_l`=0 → `q` = 0100, 0010, 0100, 1000; `word_done` pulses after the 4th shift.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load,
// with a shift counter that strobes word_done every WIDTH shifts.
//
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous active-low reset
//   en        - clock enable (0 freezes q and shift_cnt)
//   mode      - 00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r     - serial in, enters at MSB on right shift
//   sin_l     - serial in, enters at LSB on left shift
//   pin       - parallel load data
//   q         - register contents
//   sout_r    - q[0]
//   sout_l    - q[WIDTH-1]
//   shift_cnt - shifts completed in the current word
//   word_done - one-cycle strobe after the WIDTH-th shift
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             word_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             wrap;
   logic [CNT_W-1:0] cnt_nxt;

   // Counter step shared by both shift directions.
   assign wrap    = (shift_cnt == LAST);
   assign cnt_nxt = wrap ? '0 : shift_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         q         <= '0;
         shift_cnt <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (en) begin
            case (mode)
               2'b01: begin
                  q         <= {sin_r, q[WIDTH-1:1]};
                  shift_cnt <= cnt_nxt;
                  word_done <= wrap;
               end
               2'b10: begin
                  q         <= {q[WIDTH-2:0], sin_l};
                  shift_cnt <= cnt_nxt;
                  word_done <= wrap;
               end
               2'b11: begin
                  q         <= pin;
                  shift_cnt <= '0;
               end
               default: begin
                  q         <= q;
                  shift_cnt <= shift_cnt;
               end
            endcase
         end
      end
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

endmodule
